// File: rtl/wb_bram_dp_pkg.sv
// rtl/wb_bram_dp_pkg.sv - shared types and default bus widths for the dual-port Wishbone block RAM
package wb_bram_dp_pkg;

    localparam int WB_ADDR_WIDTH = 10;
    localparam int WB_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        BRAM_IDLE,
        BRAM_WAIT,
        BRAM_ACK
    } bram_port_state_t;

endpackage

// File: rtl/wb_bram_dp_if.sv
// rtl/wb_bram_dp_if.sv - classic Wishbone slave-port bundle for one block RAM port
interface wb_bram_dp_if
    import wb_bram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data_w;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    cycle;
    logic                    strobe;
    logic                    ack;

    modport master (
        output addr, data_w, sel, we, cycle, strobe,
        input  data_r, ack
    );

    modport slave (
        input  addr, data_w, sel, we, cycle, strobe,
        output data_r, ack
    );

endinterface

// File: rtl/wb_bram_dp_port_fsm.sv
// rtl/wb_bram_dp_port_fsm.sv - per-port accept/latency/ack sequencer with abort and output register
module wb_bram_dp_port_fsm
    import wb_bram_dp_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cycle,
    input  logic                  strobe,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  accept,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data_o
);

    bram_port_state_t      state;
    logic                  ack_q;
    logic                  have_data;
    logic [DATA_WIDTH-1:0] dout_q;

    assign accept = (state == BRAM_IDLE) && cycle && strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BRAM_IDLE;
            ack_q     <= 1'b0;
            have_data <= 1'b0;
            dout_q    <= '0;
        end else begin
            case (state)
                BRAM_IDLE: begin
                    ack_q <= 1'b0;
                    if (cycle && strobe) begin
                        have_data <= 1'b1;
                        if (READ_LATENCY == 2) begin
                            state <= BRAM_WAIT;
                        end else begin
                            state <= BRAM_ACK;
                            ack_q <= 1'b1;
                        end
                    end
                end
                BRAM_WAIT: begin
                    if (!cycle) begin
                        state <= BRAM_IDLE;
                    end else begin
                        state  <= BRAM_ACK;
                        ack_q  <= 1'b1;
                        dout_q <= rd_data;
                    end
                end
                BRAM_ACK: begin
                    state <= BRAM_IDLE;
                    ack_q <= 1'b0;
                end
                default: begin
                    state <= BRAM_IDLE;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end

    // A master that abandons the cycle while ack is pending must never see it.
    assign ack = ack_q & cycle;

    // Latency 1 exposes the array read register directly; gating keeps data_o at zero until the first access after reset.
    assign data_o = (READ_LATENCY == 2) ? dout_q : (have_data ? rd_data : '0);

endmodule

// File: rtl/wb_bram_dp.sv
// rtl/wb_bram_dp.sv - dual-port Wishbone classic block RAM with byte lanes and A-wins collision policy
module wb_bram_dp
    import wb_bram_dp_pkg::*;
#(
    parameter int DATA_DEPTH   = 1024,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic        wb_clock_i,
    input  logic        wb_reset_i,
    wb_bram_dp_if.slave wba,
    wb_bram_dp_if.slave wbb
);

    localparam int                LANES   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  acc_a;
    logic                  acc_b;
    logic                  in_a;
    logic                  in_b;

    assign in_a = {1'b0, wba.addr} < DEPTH_L;
    assign in_b = {1'b0, wbb.addr} < DEPTH_L;

    // Port B lanes are written first so a same-address port A write overrides them lane by lane.
    // Reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge wb_clock_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (acc_b && wbb.we && in_b && wbb.sel[i]) begin
                mem[wbb.addr][i*8 +: 8] <= wbb.data_w[i*8 +: 8];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (acc_a && wba.we && in_a && wba.sel[i]) begin
                mem[wba.addr][i*8 +: 8] <= wba.data_w[i*8 +: 8];
            end
        end
        if (acc_a) begin
            q_a <= in_a ? mem[wba.addr] : '0;
        end
        if (acc_b) begin
            q_b <= in_b ? mem[wbb.addr] : '0;
        end
    end

    wb_bram_dp_port_fsm #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_port_a (
        .clk    (wb_clock_i),
        .rst_n  (wb_reset_i),
        .cycle  (wba.cycle),
        .strobe (wba.strobe),
        .rd_data(q_a),
        .accept (acc_a),
        .ack    (wba.ack),
        .data_o (wba.data_r)
    );

    wb_bram_dp_port_fsm #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_port_b (
        .clk    (wb_clock_i),
        .rst_n  (wb_reset_i),
        .cycle  (wbb.cycle),
        .strobe (wbb.strobe),
        .rd_data(q_b),
        .accept (acc_b),
        .ack    (wbb.ack),
        .data_o (wbb.data_r)
    );

endmodule

// File: tb/tb_wb_bram_dp.sv
// tb/tb_wb_bram_dp.sv - directed self-checking bench for wb_bram_dp (8-bit/latency-1 and 16-bit/latency-2 instances)
module tb_wb_bram_dp;
    import wb_bram_dp_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    wb_bram_dp_if #(.ADDR_WIDTH(WB_ADDR_WIDTH), .DATA_WIDTH(WB_DATA_WIDTH)) a1 ();
    wb_bram_dp_if #(.ADDR_WIDTH(WB_ADDR_WIDTH), .DATA_WIDTH(WB_DATA_WIDTH)) b1 ();
    wb_bram_dp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) a2 ();
    wb_bram_dp_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) b2 ();

    wb_bram_dp #(
        .DATA_DEPTH(1024), .DATA_WIDTH(WB_DATA_WIDTH), .ADDR_WIDTH(WB_ADDR_WIDTH), .READ_LATENCY(1)
    ) dut1 (
        .wb_clock_i(clk),
        .wb_reset_i(rst_n),
        .wba       (a1),
        .wbb       (b1)
    );

    wb_bram_dp #(
        .DATA_DEPTH(1000), .DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(2)
    ) dut2 (
        .wb_clock_i(clk),
        .wb_reset_i(rst_n),
        .wba       (a2),
        .wbb       (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Optional simultaneous transfer on both ports of the 8-bit/latency-1 instance.
    task automatic xfer1(input bit ua, input bit ub, input logic wa, input logic wb,
                         input logic [9:0] aa, input logic [9:0] ab,
                         input logic [7:0] da, input logic [7:0] db,
                         output logic [7:0] ra, output logic [7:0] rb,
                         output int la, output int lb, output logic pa);
        la = 0; lb = 0; ra = '0; rb = '0; pa = 1'bx;
        @(negedge clk);
        if (ua) begin
            a1.cycle = 1'b1; a1.strobe = 1'b1; a1.we = wa; a1.addr = aa; a1.data_w = da; a1.sel = 1'b1;
        end
        if (ub) begin
            b1.cycle = 1'b1; b1.strobe = 1'b1; b1.we = wb; b1.addr = ab; b1.data_w = db; b1.sel = 1'b1;
        end
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            a1.strobe = 1'b0;
            b1.strobe = 1'b0;
            if (ua && la != 0 && n == la + 1) pa = a1.ack;
            if (ua && la == 0 && a1.ack === 1'b1) begin la = n; ra = a1.data_r; end
            if (ub && lb == 0 && b1.ack === 1'b1) begin lb = n; rb = b1.data_r; end
        end
        @(negedge clk);
        a1.cycle = 1'b0; a1.we = 1'b0;
        b1.cycle = 1'b0; b1.we = 1'b0;
    endtask

    task automatic xfer2(input logic we, input logic [9:0] addr, input logic [15:0] d,
                         input logic [1:0] sel, output logic [15:0] r, output int lat);
        lat = 0; r = '0;
        @(negedge clk);
        a2.cycle = 1'b1; a2.strobe = 1'b1; a2.we = we; a2.addr = addr; a2.data_w = d; a2.sel = sel;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            a2.strobe = 1'b0;
            if (lat == 0 && a2.ack === 1'b1) begin lat = n; r = a2.data_r; end
        end
        @(negedge clk);
        a2.cycle = 1'b0; a2.we = 1'b0;
    endtask

    logic [7:0]  ra, rb;
    logic [15:0] r2;
    int          la, lb, l2;
    logic        pa;
    logic        seen_ack;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a1.cycle = 0; a1.strobe = 0; a1.we = 0; a1.addr = '0; a1.data_w = '0; a1.sel = '0;
        b1.cycle = 0; b1.strobe = 0; b1.we = 0; b1.addr = '0; b1.data_w = '0; b1.sel = '0;
        a2.cycle = 0; a2.strobe = 0; a2.we = 0; a2.addr = '0; a2.data_w = '0; a2.sel = '0;
        b2.cycle = 0; b2.strobe = 0; b2.we = 0; b2.addr = '0; b2.data_w = '0; b2.sel = '0;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ack", {31'b0, a1.ack}, 32'h0);
        check("rst_b_ack", {31'b0, b1.ack}, 32'h0);
        check("rst_a_data", {24'b0, a1.data_r}, 32'h0);
        check("rst_b_data", {24'b0, b1.data_r}, 32'h0);
        check("rst_a2_data", {16'b0, a2.data_r}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read on port A, one-cycle ack pulse, write ack returns old word
        xfer1(1, 0, 1, 0, 10'h000, 10'h0, 8'h55, 8'h0, ra, rb, la, lb, pa);
        check("wr0_lat", la, 1);
        check("wr0_pulse", {31'b0, pa}, 32'h0);
        xfer1(1, 0, 0, 0, 10'h000, 10'h0, 8'h00, 8'h0, ra, rb, la, lb, pa);
        check("rd0_lat", la, 1);
        check("rd0_data", {24'b0, ra}, 32'h55);
        check("rd0_pulse", {31'b0, pa}, 32'h0);
        xfer1(1, 0, 1, 0, 10'h000, 10'h0, 8'h66, 8'h0, ra, rb, la, lb, pa);
        check("wr0_old", {24'b0, ra}, 32'h55);
        xfer1(1, 0, 0, 0, 10'h000, 10'h0, 8'h00, 8'h0, ra, rb, la, lb, pa);
        check("rd0_new", {24'b0, ra}, 32'h66);

        // Cross-port traffic
        xfer1(1, 0, 1, 0, 10'h3FF, 10'h0, 8'hA5, 8'h0, ra, rb, la, lb, pa);
        xfer1(0, 1, 0, 0, 10'h0, 10'h3FF, 8'h0, 8'h00, ra, rb, la, lb, pa);
        check("b_rd3ff_lat", lb, 1);
        check("b_rd3ff", {24'b0, rb}, 32'hA5);
        xfer1(0, 1, 0, 1, 10'h0, 10'h010, 8'h0, 8'h3C, ra, rb, la, lb, pa);
        xfer1(1, 0, 0, 0, 10'h010, 10'h0, 8'h00, 8'h0, ra, rb, la, lb, pa);
        check("a_rd010", {24'b0, ra}, 32'h3C);

        // Same-address collisions
        xfer1(1, 1, 1, 1, 10'h020, 10'h020, 8'h11, 8'h22, ra, rb, la, lb, pa);
        check("ww_lat_a", la, 1);
        check("ww_lat_b", lb, 1);
        xfer1(0, 1, 0, 0, 10'h0, 10'h020, 8'h0, 8'h00, ra, rb, la, lb, pa);
        check("ww_a_wins", {24'b0, rb}, 32'h11);
        xfer1(1, 0, 1, 0, 10'h021, 10'h0, 8'h00, 8'h0, ra, rb, la, lb, pa);
        xfer1(1, 1, 1, 0, 10'h021, 10'h021, 8'h77, 8'h00, ra, rb, la, lb, pa);
        check("wr_rd_first", {24'b0, rb}, 32'h00);
        xfer1(0, 1, 0, 0, 10'h0, 10'h021, 8'h0, 8'h00, ra, rb, la, lb, pa);
        check("wr_rd_later", {24'b0, rb}, 32'h77);

        // Different addresses, simultaneous, independent
        xfer1(1, 1, 1, 1, 10'h030, 10'h031, 8'h9A, 8'hBC, ra, rb, la, lb, pa);
        xfer1(1, 1, 0, 0, 10'h031, 10'h030, 8'h00, 8'h00, ra, rb, la, lb, pa);
        check("indep_a", {24'b0, ra}, 32'hBC);
        check("indep_b", {24'b0, rb}, 32'h9A);
        check("indep_lat_b", lb, 1);

        // 16-bit, latency 2, byte lanes
        xfer2(1, 10'h005, 16'hBEEF, 2'b11, r2, l2);
        check("l2_wr_lat", l2, 2);
        xfer2(1, 10'h005, 16'h1200, 2'b10, r2, l2);
        check("l2_wr_old", {16'b0, r2}, 32'hBEEF);
        xfer2(0, 10'h005, 16'h0000, 2'b00, r2, l2);
        check("l2_rd_lat", l2, 2);
        check("l2_lanes", {16'b0, r2}, 32'h12EF);

        // Abort: cycle dropped right after accept
        @(negedge clk);
        a2.cycle = 1; a2.strobe = 1; a2.we = 0; a2.addr = 10'h000;
        @(posedge clk);
        #1;
        a2.strobe = 0; a2.cycle = 0;
        seen_ack = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (a2.ack !== 1'b0) seen_ack = 1'b1;
        end
        check("abort_no_ack", {31'b0, seen_ack}, 32'h0);
        xfer2(0, 10'h005, 16'h0000, 2'b00, r2, l2);
        check("abort_next_lat", l2, 2);
        check("abort_next", {16'b0, r2}, 32'h12EF);

        // Reset asserted while in WAIT
        @(negedge clk);
        a2.cycle = 1; a2.strobe = 1; a2.we = 0; a2.addr = 10'h005;
        @(posedge clk);
        #1;
        a2.strobe = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_ack", {31'b0, a2.ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a2.cycle = 0;
        @(posedge clk);
        #1;
        check("rstw_ack2", {31'b0, a2.ack}, 32'h0);
        check("rstw_data", {16'b0, a2.data_r}, 32'h0);
        xfer2(0, 10'h005, 16'h0000, 2'b00, r2, l2);
        check("rstw_next_lat", l2, 2);
        check("rstw_next", {16'b0, r2}, 32'h12EF);

        // Out-of-range address on the 1000-word instance
        xfer2(1, 10'h000, 16'h1234, 2'b11, r2, l2);
        xfer2(1, 10'h3E8, 16'h00FF, 2'b11, r2, l2);
        check("oor_wr_lat", l2, 2);
        xfer2(0, 10'h3E8, 16'h0000, 2'b00, r2, l2);
        check("oor_rd_lat", l2, 2);
        check("oor_rd", {16'b0, r2}, 32'h0);
        xfer2(0, 10'h000, 16'h0000, 2'b00, r2, l2);
        check("oor_w0", {16'b0, r2}, 32'h1234);
        check("hold_data", {16'b0, a2.data_r}, 32'h1234);
        xfer2(0, 10'h3E7, 16'h0000, 2'b00, r2, l2);
        check("last_word_lat", l2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
